// File: rtl/serial_operand_tx_pkg.sv
// Shared definitions for the bit-serial operand path: FSM state encoding
// and the bit-counter width helper (also used by the result shift register).
package serial_operand_tx_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Width of a counter that indexes bits 0..width-1
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_operand_tx_if.sv
// Load/advance handshake and serial bit outputs of the operand transmitter.
interface serial_operand_tx_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] load_data;
   logic             rotate;
   logic             en;
   logic             ready;
   logic             bit_out;
   logic             bit_valid;
   logic             first_bit;
   logic             last_bit;
   logic             done;
   logic [WIDTH-1:0] q_out;

   // Side that loads words and strobes the serial stream
   modport master (
      output start, load_data, rotate, en,
      input  ready, bit_out, bit_valid, first_bit, last_bit, done, q_out
   );

   // The transmitter itself
   modport slave (
      input  start, load_data, rotate, en,
      output ready, bit_out, bit_valid, first_bit, last_bit, done, q_out
   );
endinterface

// File: rtl/serial_operand_tx_bit_counter.sv
// Bit index counter 0..WIDTH-1 with explicit wrap, so any WIDTH >= 2 works.
module serial_operand_tx_bit_counter
   import serial_operand_tx_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             at_zero_o,
   output logic             at_max_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, increment wraps from the last index back to 0
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign at_zero_o = (cnt_q == '0);
   assign at_max_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand source: loads a word and presents it LSB-first,
// one bit per enabled cycle, flagging the first and last bits for the ALU.
module serial_operand_tx
   import serial_operand_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_operand_tx_if.slave bus
);

   localparam int CNT_W = cnt_w(WIDTH);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic             rot_q;
   logic             rot_d;
   logic             done_q;
   logic             done_d;

   logic             accept;
   logic             consume;
   logic             at_zero;
   logic             at_max;
   // Bit index is decoded through at_zero/at_max; raw value kept for debug probing
   logic [CNT_W-1:0] cnt_dbg_unused;

   logic             ready_c;
   logic             valid_c;
   logic             first_c;
   logic             last_c;

   assign accept  = (state_q == ST_IDLE)  && bus.start;
   assign consume = (state_q == ST_SHIFT) && bus.en;

   serial_operand_tx_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (accept),
      .inc_i     (consume),
      .cnt_o     (cnt_dbg_unused),
      .at_zero_o (at_zero),
      .at_max_o  (at_max)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: load on start, return to IDLE once the last bit is consumed
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start)          state_d = ST_SHIFT;
         ST_SHIFT: if (bus.en && at_max)   state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      ready_c = 1'b0;
      valid_c = 1'b0;
      first_c = 1'b0;
      last_c  = 1'b0;
      case (state_q)
         ST_IDLE:  ready_c = 1'b1;
         ST_SHIFT: begin
            valid_c = 1'b1;
            first_c = at_zero;
            last_c  = at_max;
         end
         default:  ready_c = 1'b1;
      endcase
   end

   // Datapath next state: load, shift right with rotate or zero fill, done strobe
   always_comb begin
      shreg_d = shreg_q;
      rot_d   = rot_q;
      done_d  = consume && at_max;
      if (accept) begin
         shreg_d = bus.load_data;
         rot_d   = bus.rotate;
      end else if (consume) begin
         shreg_d = {(rot_q ? shreg_q[0] : 1'b0), shreg_q[WIDTH-1:1]};
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         rot_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         rot_q   <= rot_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready     = ready_c;
   assign bus.bit_valid = valid_c;
   assign bus.first_bit = first_c;
   assign bus.last_bit  = last_c;
   assign bus.bit_out   = shreg_q[0];
   assign bus.done      = done_q;
   assign bus.q_out     = shreg_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: table-driven transfers on a WIDTH=8 instance
// with a bit scoreboard, hand-written restart/reset sequences, and a WIDTH=5 run.
module tb_serial_operand_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   serial_operand_tx_if #(.WIDTH(8)) if8 ();
   serial_operand_tx_if #(.WIDTH(5)) if5 ();

   serial_operand_tx #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   serial_operand_tx #(.WIDTH(5)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if5)
   );

   typedef struct {
      bit b;
      bit first;
      bit last;
   } exp_bit_t;

   typedef struct {
      logic [7:0] data;
      bit         rot;
      int         stall_lo;
      int         stall_hi;
      int         spur_c;
      logic [7:0] spur_d;
      logic [7:0] stream;
      logic [7:0] qend;
      int         done_c;
   } vec_t;

   exp_bit_t   sbq[$];
   vec_t       vecs[5];
   int         checks   = 0;
   int         errors   = 0;
   bit         exp_done = 1'b0;
   logic [7:0] exp_qend = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle on the WIDTH=8 instance: compare outputs against the scoreboard,
   // then drive the inputs for the next rising edge.
   task automatic cyc8(input bit st, input logic [7:0] d, input bit rot, input bit e,
                       input logic [7:0] stream, input logic [7:0] qend);
      bit       idle_now;
      exp_bit_t h;
      @(negedge clk);
      chk("done", if8.done, exp_done);
      if (exp_done) chk("q_out_end", if8.q_out, exp_qend);
      exp_done = 1'b0;
      idle_now = (sbq.size() == 0);
      chk("ready", if8.ready, idle_now);
      chk("bit_valid", if8.bit_valid, !idle_now);
      if (!idle_now) begin
         h = sbq[0];
         chk("bit_out", if8.bit_out, h.b);
         chk("first_bit", if8.first_bit, h.first);
         chk("last_bit", if8.last_bit, h.last);
         if (e) begin
            void'(sbq.pop_front());
            if (h.last) exp_done = 1'b1;
         end
      end
      if8.start     = st;
      if8.load_data = d;
      if8.rotate    = rot;
      if8.en        = e;
      if (st && idle_now) begin
         for (int k = 0; k < 8; k++) sbq.push_back('{stream[k], k == 0, k == 7});
         exp_qend = qend;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int         seen;
      bit         st;
      bit         e;
      logic [7:0] d;
      seen = -1;
      cyc8(1'b1, v.data, v.rot, 1'b1, v.stream, v.qend);
      for (int c = 1; c <= v.done_c; c++) begin
         st = (c == v.spur_c);
         e  = !(c >= v.stall_lo && c <= v.stall_hi);
         d  = st ? v.spur_d : 8'h00;
         cyc8(st, d, !v.rot, e, 8'h00, 8'h00);
         if (if8.done) seen = c;
      end
      cyc8(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("done_cycle", seen, v.done_c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp5[5];

      if8.start = 1'b0; if8.load_data = '0; if8.rotate = 1'b0; if8.en = 1'b0;
      if5.start = 1'b0; if5.load_data = '0; if5.rotate = 1'b0; if5.en = 1'b0;

      //            data   rot lo  hi  spur spur_d stream qend   done
      vecs[0] = '{8'hA5, 1'b0, 0, -1,  8, 8'hFF, 8'hA5, 8'h00, 9};
      vecs[1] = '{8'hA5, 1'b1, 0, -1, -1, 8'h00, 8'hA5, 8'hA5, 9};
      vecs[2] = '{8'h81, 1'b0, 3,  5, -1, 8'h00, 8'h81, 8'h00, 12};
      vecs[3] = '{8'hFF, 1'b0, 0, -1,  5, 8'h00, 8'hFF, 8'h00, 9};
      vecs[4] = '{8'h3C, 1'b1, 0, -1, -1, 8'h00, 8'h3C, 8'h3C, 9};
      exp5    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", if8.ready, 1'b1);
      chk("rst_bit_valid", if8.bit_valid, 1'b0);
      chk("rst_bit_out", if8.bit_out, 1'b0);
      chk("rst_first", if8.first_bit, 1'b0);
      chk("rst_last", if8.last_bit, 1'b0);
      chk("rst_done", if8.done, 1'b0);
      chk("rst_q_out", if8.q_out, 8'h00);
      chk("rst_ready5", if5.ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Rotating transfer, then restart in the done cycle
      cyc8(1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 8'hA5);
      for (int c = 1; c <= 8; c++) cyc8(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00);
      chk("done_before_restart", if8.done, 1'b0);
      cyc8(1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 8'h00);
      for (int c = 1; c <= 9; c++) cyc8(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00);
      cyc8(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      // Asynchronous reset mid-transfer at bit 5
      cyc8(1'b1, 8'hF0, 1'b0, 1'b1, 8'hF0, 8'h00);
      for (int c = 1; c <= 6; c++) cyc8(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", if8.ready, 1'b1);
      chk("mid_rst_bit_valid", if8.bit_valid, 1'b0);
      chk("mid_rst_q_out", if8.q_out, 8'h00);
      chk("mid_rst_last", if8.last_bit, 1'b0);
      sbq.delete();
      exp_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      if8.en = 1'b0;
      cyc8(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc8(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      run_vec(vecs[0]);

      // WIDTH=5 instance: two rotating transfers of 5'b10011
      for (int rep = 0; rep < 2; rep++) begin
         @(negedge clk);
         if5.start = 1'b1; if5.load_data = 5'b10011; if5.rotate = 1'b1; if5.en = 1'b1;
         @(negedge clk);
         if5.start = 1'b0;
         for (int k = 0; k < 5; k++) begin
            chk("w5_bit_valid", if5.bit_valid, 1'b1);
            chk("w5_bit_out", if5.bit_out, exp5[k]);
            chk("w5_first", if5.first_bit, k == 0);
            chk("w5_last", if5.last_bit, k == 4);
            @(negedge clk);
         end
         chk("w5_done", if5.done, 1'b1);
         chk("w5_ready", if5.ready, 1'b1);
         chk("w5_q_out", if5.q_out, 5'b10011);
         @(negedge clk);
         chk("w5_done_clear", if5.done, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
